chirp_sweep_gen: RTL and testbench

Parametrised chirp sweep generator feeding a DDS phase/LUT core in the clk_96 domain.
- Produces a stepped frequency word (phase increment) and a running phase accumulator.
- Supports up-saw, down-saw, triangle and CW modes, with a finite or infinite sweep repeat count.
- Configuration uses a valid/ready handshake into shadow registers; sweep runs are started by an edge and aborted by a stop.

---
 rtl/chirp_pkg.sv | 22 ++
 rtl/dds_phase_acc.sv | 33 +++
 rtl/chirp_sweep_gen.sv | 204 ++++++++++++++++++++
 tb/tb_chirp_sweep_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared types and default widths for the chirp sweep generator.
package chirp_pkg;

  localparam int unsigned FW_DEF = 48;  // frequency word / phase accumulator width
  localparam int unsigned RW_DEF = 32;  // dwell counter width
  localparam int unsigned NW_DEF = 24;  // step counter width
  localparam int unsigned PW_DEF = 16;  // truncated phase output width

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_CW   = 2'd3
  } chirp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chirp_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator for the DDS path.
// Ports:
//   clk_96 - clock
//   rst    - synchronous reset, active-high
//   clr    - synchronous clear (wins over en)
//   en     - add inc into the accumulator this cycle
//   inc    - phase increment (frequency word)
//   phase  - top PW bits of the accumulator (pre-add value)
module dds_phase_acc #(
  parameter int unsigned FW = 48,
  parameter int unsigned PW = 16
) (
  input  logic          clk_96,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [FW-1:0] inc,
  output logic [PW-1:0] phase
);

  logic [FW-1:0] acc_q;

  always_ff @(posedge clk_96) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + inc;
    end
  end

  assign phase = acc_q[FW-1 -: PW];

endmodule

// File: rtl/chirp_sweep_gen.sv
// Stepped chirp sweep generator: produces a frequency word and truncated running phase
// for a DDS core. Modes: up-saw, down-saw, triangle, CW; finite or infinite repeat.
// Ports:
//   clk_96, rst            - clock, synchronous active-high reset
//   cfg_valid/cfg_ready    - config handshake into shadow registers (accepted in IDLE)
//   cfg_freq/delta/rate/steps/mode/repeat - sweep configuration
//   start (rising edge), stop (level abort)
//   busy, done, sweep_sync - status
//   phi_inc_o, phase_o, out_valid - DDS outputs
module chirp_sweep_gen
  import chirp_pkg::*;
#(
  parameter int unsigned FW = FW_DEF,
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk_96,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_freq,
  input  logic [FW-1:0] cfg_delta,
  input  logic [RW-1:0] cfg_rate,
  input  logic [NW-1:0] cfg_steps,
  input  logic [1:0]    cfg_mode,
  input  logic [7:0]    cfg_repeat,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          sweep_sync,
  output logic [FW-1:0] phi_inc_o,
  output logic [PW-1:0] phase_o,
  output logic          out_valid
);

  chirp_state_e state_q, state_d;
  logic          start_q;
  logic          start_edge, cfg_acc;

  // Shadow configuration
  logic [FW-1:0] f0_q, delta_q;
  logic [RW-1:0] rate_q;
  logic [NW-1:0] steps_q;
  chirp_mode_e   mode_q, mode_eff;
  logic [7:0]    repeat_q;

  // Sweep progress
  logic [FW-1:0] freq_q, freq_d;
  logic [RW-1:0] dwell_q, dwell_d;
  logic [NW-1:0] step_q, step_d;
  logic          dir_q, dir_d;  // TRI only: 1 on the falling half
  logic [7:0]    sweep_q, sweep_d;
  logic          sweep_end;
  logic [PW-1:0] acc_phase;

  assign start_edge = start & ~start_q;
  assign cfg_acc    = cfg_valid & cfg_ready;
  // A triangle with no steps degenerates to a constant tone.
  assign mode_eff   = (mode_q == MODE_TRI && steps_q == '0) ? MODE_CW : mode_q;

  always_comb begin
    state_d   = state_q;
    freq_d    = '0;
    dwell_d   = '0;
    step_d    = '0;
    dir_d     = 1'b0;
    sweep_d   = '0;
    sweep_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_RUN;
          // Config landing in the same cycle as the edge takes effect for this run.
          freq_d  = cfg_acc ? cfg_freq : f0_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          freq_d  = freq_q;
          step_d  = step_q;
          dir_d   = dir_q;
          sweep_d = sweep_q;
          if (dwell_q != rate_q) begin
            dwell_d = dwell_q + RW'(1);
          end else begin
            case (mode_eff)
              MODE_UP: begin
                if (step_q == steps_q) begin
                  sweep_end = 1'b1;
                end else begin
                  step_d = step_q + NW'(1);
                  freq_d = freq_q + delta_q;
                end
              end
              MODE_DOWN: begin
                if (step_q == steps_q) begin
                  sweep_end = 1'b1;
                end else begin
                  step_d = step_q + NW'(1);
                  freq_d = freq_q - delta_q;
                end
              end
              MODE_TRI: begin
                // step_q is the multiple of delta above f0; the fall stops at f0+d.
                if (!dir_q) begin
                  if (step_q != steps_q) begin
                    step_d = step_q + NW'(1);
                    freq_d = freq_q + delta_q;
                  end else if (steps_q == NW'(1)) begin
                    sweep_end = 1'b1;
                  end else begin
                    dir_d  = 1'b1;
                    step_d = steps_q - NW'(1);
                    freq_d = freq_q - delta_q;
                  end
                end else if (step_q == NW'(1)) begin
                  sweep_end = 1'b1;
                end else begin
                  step_d = step_q - NW'(1);
                  freq_d = freq_q - delta_q;
                end
              end
              default: sweep_end = 1'b1;
            endcase
            if (sweep_end) begin
              step_d = '0;
              dir_d  = 1'b0;
              freq_d = f0_q;
              if (repeat_q != 8'd0 && sweep_q == repeat_q - 8'd1) begin
                state_d = ST_DONE;
                freq_d  = '0;
                sweep_d = '0;
              end else if (repeat_q != 8'd0) begin
                sweep_d = sweep_q + 8'd1;
              end
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_96) begin
    if (rst) begin
      // Track start during reset so a level held through reset is not seen as an edge.
      start_q  <= start;
      state_q  <= ST_IDLE;
      f0_q     <= '0;
      delta_q  <= '0;
      rate_q   <= '0;
      steps_q  <= '0;
      mode_q   <= MODE_UP;
      repeat_q <= '0;
      freq_q   <= '0;
      dwell_q  <= '0;
      step_q   <= '0;
      dir_q    <= 1'b0;
      sweep_q  <= '0;
    end else begin
      start_q <= start;
      state_q <= state_d;
      freq_q  <= freq_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      sweep_q <= sweep_d;
      if (cfg_acc) begin
        f0_q     <= cfg_freq;
        delta_q  <= cfg_delta;
        rate_q   <= cfg_rate;
        steps_q  <= cfg_steps;
        mode_q   <= chirp_mode_e'(cfg_mode);
        repeat_q <= cfg_repeat;
      end
    end
  end

  dds_phase_acc #(
    .FW (FW),
    .PW (PW)
  ) u_acc (
    .clk_96 (clk_96),
    .rst    (rst),
    .clr    (!busy || stop),
    .en     (busy),
    .inc    (freq_q),
    .phase  (acc_phase)
  );

  assign busy       = (state_q == ST_RUN);
  assign out_valid  = busy;
  assign done       = (state_q == ST_DONE);
  assign cfg_ready  = (state_q == ST_IDLE) && !rst;
  assign phi_inc_o  = busy ? freq_q : '0;
  assign phase_o    = busy ? acc_phase : '0;
  assign sweep_sync = busy && dwell_q == '0 && step_q == '0 && !dir_q;

endmodule

// File: tb/tb_chirp_sweep_gen.sv
module tb_chirp_sweep_gen;

  logic        clk_96 = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [47:0] cfg_freq, cfg_delta;
  logic [31:0] cfg_rate;
  logic [23:0] cfg_steps;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_repeat;
  logic        start, stop;
  logic        busy, done, sweep_sync, out_valid;
  logic [47:0] phi_inc_o;
  logic [15:0] phase_o;

  always #5 clk_96 = ~clk_96;

  chirp_sweep_gen dut (
    .clk_96     (clk_96),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_freq   (cfg_freq),
    .cfg_delta  (cfg_delta),
    .cfg_rate   (cfg_rate),
    .cfg_steps  (cfg_steps),
    .cfg_mode   (cfg_mode),
    .cfg_repeat (cfg_repeat),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .sweep_sync (sweep_sync),
    .phi_inc_o  (phi_inc_o),
    .phase_o    (phase_o),
    .out_valid  (out_valid)
  );

  typedef struct packed {
    logic        b;
    logic        ov;
    logic        sy;
    logic        dn;
    logic [47:0] phi;
    logic [15:0] ph;
  } obs_t;

  typedef struct {
    logic [47:0] f0;
    logic [47:0] d;
    logic [31:0] rate;
    logic [23:0] n;
    logic [1:0]  mode;
    logic [7:0]  rep;
    int          exp_busy;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  vec_t vecs[7];

  function automatic obs_t sample();
    obs_t o;
    o = '{b: busy, ov: out_valid, sy: sweep_sync, dn: done, phi: phi_inc_o, ph: phase_o};
    return o;
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference sequence: list the frequency values of one sweep, then expand by dwell and repeat.
  task automatic push_expected(input vec_t v);
    logic [47:0] vals[$];
    logic [47:0] acc;
    obs_t        e;
    if (v.mode == 2'd3 || (v.mode == 2'd2 && v.n == 0)) begin
      vals.push_back(v.f0);
    end else if (v.mode == 2'd0) begin
      for (int k = 0; k <= int'(v.n); k++) vals.push_back(v.f0 + 48'(k) * v.d);
    end else if (v.mode == 2'd1) begin
      for (int k = 0; k <= int'(v.n); k++) vals.push_back(v.f0 - 48'(k) * v.d);
    end else begin
      for (int k = 0; k <= int'(v.n); k++) vals.push_back(v.f0 + 48'(k) * v.d);
      for (int k = int'(v.n) - 1; k >= 1; k--) vals.push_back(v.f0 + 48'(k) * v.d);
    end
    acc = '0;
    for (int r = 0; r < int'(v.rep); r++) begin
      for (int j = 0; j < vals.size(); j++) begin
        for (int c = 0; c <= int'(v.rate); c++) begin
          e = '{b: 1'b1, ov: 1'b1, sy: (j == 0 && c == 0), dn: 1'b0, phi: vals[j], ph: acc[47:32]};
          exp_q.push_back(e);
          acc = acc + vals[j];
        end
      end
    end
    e = '{b: 1'b0, ov: 1'b0, sy: 1'b0, dn: 1'b1, phi: '0, ph: '0};
    exp_q.push_back(e);
  endtask

  task automatic load_cfg(input vec_t v);
    @(negedge clk_96);
    cfg_freq   = v.f0;
    cfg_delta  = v.d;
    cfg_rate   = v.rate;
    cfg_steps  = v.n;
    cfg_mode   = v.mode;
    cfg_repeat = v.rep;
    cfg_valid  = 1'b1;
    chk("cfg_ready_idle", cfg_ready, 1);
    @(negedge clk_96);
    cfg_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    obs_t o, e;
    int   bc, cyc;
    load_cfg(v);
    start = 1'b1;
    push_expected(v);
    bc  = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_96);
      start = 1'b0;
      o = sample();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_cyc%0d", idx, cyc), o, e);
      if (o.b) bc++;
      cyc++;
    end
    chk($sformatf("vec%0d_busy_len", idx), bc, v.exp_busy);
    @(negedge clk_96);
    chk($sformatf("vec%0d_idle_after", idx), {cfg_ready, sample()}, {1'b1, 68'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0] = '{f0: 48'd1000, d: 48'd10, rate: 32'd2, n: 24'd3, mode: 2'd0, rep: 8'd2, exp_busy: 24};
    vecs[1] = '{f0: 48'd100, d: 48'd5, rate: 32'd0, n: 24'd2, mode: 2'd2, rep: 8'd1, exp_busy: 4};
    vecs[2] = '{f0: 48'd3, d: 48'd5, rate: 32'd0, n: 24'd1, mode: 2'd1, rep: 8'd1, exp_busy: 2};
    vecs[3] = '{f0: 48'd77, d: 48'd9, rate: 32'd1, n: 24'd0, mode: 2'd2, rep: 8'd2, exp_busy: 4};
    vecs[4] = '{f0: 48'h0123_4567_89AB, d: 48'd0, rate: 32'd3, n: 24'd5, mode: 2'd3, rep: 8'd2,
                exp_busy: 8};
    vecs[5] = '{f0: 48'd50, d: 48'd7, rate: 32'd1, n: 24'd1, mode: 2'd2, rep: 8'd2, exp_busy: 8};
    vecs[6] = '{f0: 48'hFFFF_FFFF_FFF6, d: 48'd7, rate: 32'd0, n: 24'd3, mode: 2'd0, rep: 8'd1,
                exp_busy: 4};

    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_freq = '0; cfg_delta = '0; cfg_rate = '0; cfg_steps = '0; cfg_mode = '0; cfg_repeat = '0;
    repeat (2) @(negedge clk_96);
    chk("reset_outputs", {cfg_ready, sample()}, 69'd0);
    rst = 1'b0;
    @(negedge clk_96);
    chk("post_reset", {cfg_ready, sample()}, {1'b1, 68'd0});

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // CW, infinite repeat: phase steps by 2^12 per cycle, stop aborts without done.
    v = '{f0: 48'h1000_0000_0000, d: 48'd0, rate: 32'd0, n: 24'd0, mode: 2'd3, rep: 8'd0,
          exp_busy: 0};
    load_cfg(v);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_96);
      start = 1'b0;
      chk($sformatf("cw_phase%0d", i), {busy, phi_inc_o, phase_o},
          {1'b1, 48'h1000_0000_0000, 16'(i * 4096)});
    end
    stop = 1'b1;
    @(negedge clk_96);
    chk("cw_stop", sample(), 68'd0);
    @(negedge clk_96);
    chk("cw_stop_no_done", {done, busy}, 2'b00);
    // Start edge with stop already high in IDLE still launches the run.
    start = 1'b1;
    @(negedge clk_96);
    chk("stop_idle_start", {busy, phi_inc_o}, {1'b1, 48'h1000_0000_0000});
    start = 1'b0;
    @(negedge clk_96);
    chk("stop_idle_abort", {busy, done}, 2'b00);
    stop = 1'b0;

    // Config accept coincident with start edge; second edge during RUN is ignored.
    v = '{f0: 48'd500, d: 48'd1, rate: 32'd0, n: 24'd2, mode: 2'd0, rep: 8'd1, exp_busy: 0};
    load_cfg(v);
    @(negedge clk_96);
    cfg_freq = 48'd7000; cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk_96);
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfgstart_f0", {busy, cfg_ready, phi_inc_o}, {2'b10, 48'd7000});
    @(negedge clk_96);
    chk("cfgstart_s1", phi_inc_o, 48'd7001);
    start = 1'b1;
    @(negedge clk_96);
    chk("cfgstart_s2", phi_inc_o, 48'd7002);
    @(negedge clk_96);
    chk("cfgstart_done", {busy, done}, 2'b01);
    @(negedge clk_96);
    chk("second_edge_ignored", {busy, cfg_ready}, 2'b01);
    @(negedge clk_96);
    chk("second_edge_still_idle", busy, 0);
    start = 1'b0;

    // Reset mid-run with start held high.
    v = '{f0: 48'd900, d: 48'd3, rate: 32'd1, n: 24'd4, mode: 2'd0, rep: 8'd0, exp_busy: 0};
    load_cfg(v);
    start = 1'b1;
    repeat (3) @(negedge clk_96);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk_96);
    chk("in_reset_ready", cfg_ready, 0);
    rst = 1'b0;
    @(negedge clk_96);
    chk("after_midrun_reset", {cfg_ready, sample()}, {1'b1, 68'd0});
    repeat (3) @(negedge clk_96);
    chk("held_start_no_run", busy, 0);
    start = 1'b0;
    @(negedge clk_96);
    start = 1'b1;
    @(negedge clk_96);
    start = 1'b0;
    chk("restart_cleared_shadow", {busy, phi_inc_o}, {1'b1, 48'd0});
    stop = 1'b1;
    @(negedge clk_96);
    stop = 1'b0;
    chk("final_stop", {busy, done}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
